// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the scoreboarded register file.
// Sized for the default RV32 configuration.
package reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/reg_file_rdport.sv
// One read port: x0 forcing, write forwarding and busy lookup.
// Purely combinational; replicated once per read port.
module reg_file_rdport
    import reg_file_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int AW     = $clog2(NREGS),
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]              addr,
    input  logic [NREGS-1:0][XLEN-1:0] regs,
    input  logic [NREGS-1:0]           busy,
    input  logic                       wa_en,
    input  logic [AW-1:0]              wa_addr,
    input  logic [XLEN-1:0]            wa_data,
    input  logic                       wb_en,
    input  logic [AW-1:0]              wb_addr,
    input  logic [XLEN-1:0]            wb_data,
    output logic [XLEN-1:0]            data,
    output logic                       busy_o
);

    logic wa_hit;
    logic wb_hit;

    // Select read data by priority: x0, port B, port A, stored value
    always_comb begin
        wa_hit = (BYPASS != 0) && wa_en && (wa_addr == addr);
        wb_hit = (BYPASS != 0) && wb_en && (wb_addr == addr);
        data   = regs[addr];
        busy_o = busy[addr];
        if (addr == '0) begin
            data = '0;
        end else if (wb_hit) begin
            data = wb_data;
        end else if (wa_hit) begin
            data = wa_data;
        end
        if (wb_hit || (addr == '0)) begin
            busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with long-latency scoreboard and hazard flag.
// Port A is single-cycle, port B retires mul/div results.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]  rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         wa_en,
    input  logic [AW-1:0]                wa_addr,
    input  logic [XLEN-1:0]              wa_data,
    input  logic                         wb_en,
    input  logic [AW-1:0]                wb_addr,
    input  logic [XLEN-1:0]              wb_data,
    input  logic                         iss_en,
    input  logic [AW-1:0]                iss_addr,
    output logic                         stall,
    output logic                         err
);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           busy_q, busy_d;
    logic                       err_q, err_d;

    logic wa_v, wb_v, iss_v, iss_wb;

    // Next-state for storage, scoreboard and sticky hazard flag
    always_comb begin
        wa_v   = wa_en && (wa_addr != '0);
        wb_v   = wb_en && (wb_addr != '0);
        iss_v  = iss_en && (iss_addr != '0);
        iss_wb = iss_v && wb_v && (iss_addr == wb_addr);
        regs_d = regs_q;
        busy_d = busy_q;
        err_d  = err_q;
        if (wa_v) begin
            regs_d[wa_addr] = wa_data;
            if (busy_q[wa_addr]) err_d = 1'b1;
        end
        if (wb_v) begin
            regs_d[wb_addr] = wb_data;
            busy_d[wb_addr] = 1'b0;
            if (!busy_q[wb_addr] && !iss_wb) err_d = 1'b1;
            if (wa_v && (wa_addr == wb_addr)) err_d = 1'b1;
        end
        if (iss_v) begin
            busy_d[iss_addr] = 1'b1;
            if (busy_q[iss_addr] && !iss_wb) err_d = 1'b1;
        end
        busy_d[0] = 1'b0;
        regs_d[0] = '0;
    end

    // State update; reset drops all data and pending ops
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_RD; g++) begin : g_rd
            reg_file_rdport #(
                .XLEN   (XLEN),
                .NREGS  (NREGS),
                .AW     (AW),
                .BYPASS (BYPASS)
            ) u_rdport (
                .addr    (rd_addr[g]),
                .regs    (regs_q),
                .busy    (busy_q),
                .wa_en   (wa_en),
                .wa_addr (wa_addr),
                .wa_data (wa_data),
                .wb_en   (wb_en),
                .wb_addr (wb_addr),
                .wb_data (wb_data),
                .data    (rd_data[g]),
                .busy_o  (rd_busy[g])
            );
        end
    endgenerate

    assign stall = |rd_busy;
    assign err   = err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench: one bypassing and one
// non-bypassing instance driven with identical stimulus.
module tb_reg_file_sb;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0][4:0] rd_addr;
    logic            wa_en, wb_en, iss_en;
    logic [4:0]      wa_addr, wb_addr, iss_addr;
    logic [31:0]     wa_data, wb_data;

    logic [1:0][31:0] rd_data, rd_data0;
    logic [1:0]       rd_busy, rd_busy0;
    logic             stall, stall0, err, err0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    reg_file_sb #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .stall(stall), .err(err)
    );

    reg_file_sb #(.BYPASS(0)) dut0 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_busy(rd_busy0),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .stall(stall0), .err(err0)
    );

    // sig: 0/1 data port, 2/3 busy port, 4 stall, 5 err; +10 = no-bypass DUT
    function automatic logic [31:0] obs(int s);
        case (s)
            0:  return rd_data[0];
            1:  return rd_data[1];
            2:  return 32'(rd_busy[0]);
            3:  return 32'(rd_busy[1]);
            4:  return 32'(stall);
            5:  return 32'(err);
            10: return rd_data0[0];
            11: return rd_data0[1];
            12: return 32'(rd_busy0[0]);
            13: return 32'(rd_busy0[1]);
            14: return 32'(stall0);
            15: return 32'(err0);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic push(input string t, input int s, input logic [31:0] v);
        sb.push_back('{t, s, v});
    endtask

    task automatic push2(input string t, input int s, input logic [31:0] v);
        push(t, s, v);
        push({t, "_nb"}, s + 10, v);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sig);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s got %0h exp %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic idle();
        wa_en = 0; wa_addr = 0; wa_data = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        iss_en = 0; iss_addr = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1;
        rd_addr = '0;
        idle();
        cyc();
        cyc();
        reset = 0;
        rd_addr[0] = 5'd1;
        rd_addr[1] = 5'd31;
        #1;
        push2("rst_d0", 0, 0);
        push2("rst_d1", 1, 0);
        push2("rst_b0", 2, 0);
        push2("rst_b1", 3, 0);
        push2("rst_stall", 4, 0);
        push2("rst_err", 5, 0);
        drain();

        for (int k = 1; k <= 4; k++) begin
            wa_en = 1; wa_addr = 5'(k); wa_data = 32'(k * 10);
            cyc();
        end
        idle();
        for (int k = 1; k <= 4; k++) begin
            rd_addr[0] = 5'(k);
            rd_addr[1] = 5'(5 - k);
            #1;
            push2("wr_p0", 0, 32'(k * 10));
            push2("wr_p1", 1, 32'((5 - k) * 10));
            drain();
        end
        rd_addr[0] = 0;
        #1;
        push2("x0_rd", 0, 0);
        drain();

        wa_en = 1; wa_addr = 0; wa_data = 32'hDEADBEEF;
        wb_en = 1; wb_addr = 0; wb_data = 32'hDEADBEEF;
        rd_addr[1] = 0;
        #1;
        push2("x0_byp0", 0, 0);
        push2("x0_byp1", 1, 0);
        drain();
        cyc();
        idle();
        #1;
        push2("x0_after", 0, 0);
        push2("x0_busy", 2, 0);
        push2("x0_err", 5, 0);
        drain();

        iss_en = 1; iss_addr = 5;
        cyc();
        idle();
        rd_addr[0] = 5; rd_addr[1] = 1;
        #1;
        push2("x5_busy", 2, 1);
        push2("x5_stall", 4, 1);
        drain();
        wb_en = 1; wb_addr = 5; wb_data = 32'h1234;
        #1;
        push("x5_fwd", 0, 32'h1234);
        push("x5_fwd_busy", 2, 0);
        push("x5_fwd_stall", 4, 0);
        push("x5_nofwd", 10, 0);
        push("x5_nofwd_busy", 12, 1);
        drain();
        cyc();
        idle();
        #1;
        push2("x5_reg", 0, 32'h1234);
        push2("x5_clr", 2, 0);
        push2("x5_err", 5, 0);
        drain();

        iss_en = 1; iss_addr = 9;
        cyc();
        iss_en = 1; iss_addr = 9;
        wb_en = 1; wb_addr = 9; wb_data = 32'h55;
        rd_addr[0] = 9;
        #1;
        push("x9_fwd", 0, 32'h55);
        drain();
        cyc();
        idle();
        #1;
        push2("x9_reg", 0, 32'h55);
        push2("x9_busy", 2, 1);
        push2("x9_err", 5, 0);
        drain();
        wb_en = 1; wb_addr = 9; wb_data = 32'h66;
        cyc();
        idle();
        #1;
        push2("x9_reg2", 0, 32'h66);
        push2("x9_busy2", 2, 0);
        push2("x9_err2", 5, 0);
        drain();

        iss_en = 1; iss_addr = 7;
        cyc();
        idle();
        wa_en = 1; wa_addr = 7; wa_data = 1;
        wb_en = 1; wb_addr = 7; wb_data = 2;
        rd_addr[0] = 7;
        #1;
        push("x7_fwd", 0, 2);
        drain();
        cyc();
        idle();
        #1;
        push2("x7_reg", 0, 2);
        push2("x7_err", 5, 1);
        push2("x7_busy", 2, 0);
        drain();
        cyc();
        cyc();
        #1;
        push2("err_sticky", 5, 1);
        drain();

        iss_en = 1; iss_addr = 3;
        cyc();
        idle();
        rd_addr[0] = 3;
        #1;
        push2("x3_busy", 2, 1);
        drain();
        reset = 1;
        cyc();
        reset = 0;
        #1;
        push2("x3_rst_busy", 2, 0);
        push2("x3_rst_data", 0, 0);
        push2("x3_rst_err", 5, 0);
        push2("x3_rst_stall", 4, 0);
        drain();
        wb_en = 1; wb_addr = 3; wb_data = 7;
        cyc();
        idle();
        #1;
        push2("x3_spur_err", 5, 1);
        push2("x3_reg", 0, 7);
        drain();
        wa_en = 1; wa_addr = 2; wa_data = 9;
        rd_addr[1] = 2;
        #1;
        push("x2_fwd", 1, 9);
        push("x2_nofwd", 11, 0);
        drain();
        cyc();
        idle();
        #1;
        push2("x2_reg", 1, 9);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning data width.
REQ-002 The module SHALL have parameter NREGS, default 32, meaning register count (power of 2); AW = clog2(NREGS).
REQ-003 The module SHALL have parameter NUM_RD, default 2, meaning number of read ports (1..4).
REQ-004 The module SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding and 0 = none.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port rd_addr, input, NUM_RD x AW: read addresses.
REQ-008 The module SHALL have port rd_data, output, NUM_RD x XLEN: combinational read data.
REQ-009 The module SHALL have port rd_busy, output, NUM_RD: addressed register has a pending long-latency write.
REQ-010 The module SHALL have ports wa_en (input, 1), wa_addr (input, AW) and wa_data (input, XLEN): single-cycle (ALU) write port A.
REQ-011 The module SHALL have ports wb_en (input, 1), wb_addr (input, AW) and wb_data (input, XLEN): long-latency (mul/div) write port B.
REQ-012 The module SHALL have ports iss_en (input, 1) and iss_addr (input, AW): issue of a long-latency op targeting iss_addr.
REQ-013 The module SHALL have port stall, output, 1: OR of rd_busy over all read ports.
REQ-014 The module SHALL have port err, output, 1: sticky hazard-violation flag.

Function
REQ-015 Register 0 SHALL always read 0, ignore writes, and never become busy.
REQ-016 The module SHALL write wa_data into regs[wa_addr] at the clock edge when wa_en=1 and wa_addr!=0.
REQ-017 The module SHALL write wb_data into regs[wb_addr] and clear busy[wb_addr] at the clock edge when wb_en=1 and wb_addr!=0.
REQ-018 When both ports write the same nonzero address in one cycle, port B data SHALL win and err SHALL set.
REQ-019 The module SHALL set busy[iss_addr] at the clock edge when iss_en=1 and iss_addr!=0.
REQ-020 When iss_en and wb_en target the same address in one cycle, the register data SHALL be written, busy SHALL end set (issue wins), and err SHALL NOT be raised.
REQ-021 When iss_en=1 and busy[iss_addr]=1 with no same-cycle clear, err SHALL set (WAW on a pending register); busy SHALL stay 1.
REQ-022 When wa_en=1 and busy[wa_addr]=1, err SHALL set and the write SHALL still occur.
REQ-023 When wb_en=1 and busy[wb_addr]=0, err SHALL set (spurious writeback) and the write SHALL still occur.
REQ-024 With BYPASS=1, each read port SHALL return, combinationally and in priority order: 0 if addr=0; wb_data if wb_en and wb_addr match; wa_data if wa_en and wa_addr match; else regs[addr].
REQ-025 With BYPASS=0, each read port SHALL return the pre-edge register contents (write visible the cycle after).
REQ-026 rd_busy[i] SHALL equal busy[rd_addr[i]], excluding any bit cleared by a same-cycle wb_en when BYPASS=1.
REQ-027 Read latency SHALL be 0 cycles; write latency SHALL be 1 cycle; busy set/clear latency SHALL be 1 cycle.
REQ-028 err SHALL remain set until reset.

Reset
REQ-029 While reset=1 at a clock edge, all registers SHALL clear to 0, all busy bits SHALL clear, and err SHALL clear; the write and issue ports SHALL be ignored that cycle.
REQ-030 After reset, rd_data SHALL be 0 for every address, rd_busy=0, stall=0, and err=0.
REQ-031 Reset asserted during pending long-latency ops SHALL drop all pending state; a later wb_en SHALL raise err per REQ-023.

Structure
REQ-032 A package reg_file_pkg SHALL hold XLEN_DEF, NREGS_DEF, and the reg_addr_t and xlen_t typedefs.
REQ-033 One sub-module, reg_file_rdport (bypass and busy mux for one read port), SHALL be instantiated NUM_RD times by a generate loop.
REQ-034 Storage SHALL be a flat array of NREGS x XLEN flops with no RAM inference (reset clears all).

Verification
REQ-035 Reset, then write x1..x4 = 10, 20, 30, 40 via port A -> reading port0 = 1..4 and port1 = 4..1 returns the matching values one cycle later; x0 reads 0.
REQ-036 Write x0 = 0xDEADBEEF on both ports -> x0 reads 0; busy stays 0; err=0.
REQ-037 iss x5; next cycle read x5 -> rd_busy=1 and stall=1; wb x5 = 0x1234 -> same-cycle read returns 0x1234 with rd_busy=0 (BYPASS=1); next cycle regs[x5] = 0x1234.
REQ-038 Same cycle wa x7 = 1 and wb x7 = 2 (x7 busy) -> x7 = 2 and err=1; err persists until reset.
REQ-039 Same cycle iss x9 and wb x9 = 0x55 (x9 busy) -> x9 = 0x55, busy[x9]=1, err=0.
REQ-040 iss x3, then reset, then wb x3 = 7 -> busy[x3]=0 after reset and err=1 after the wb; with BYPASS=0, a wa x2 = 9 read in the same cycle returns the old value 0.
